// File: rtl/onchip_mem_arbiter.sv
// onchip_mem_arbiter: round-robin sharing of a single-port RAM between two Avalon-MM requesters, with a zero-fill engine.
module onchip_mem_arbiter #(
  parameter int ADDR_W = 13,
  parameter int DATA_W = 16,
  parameter int BE_W   = 2,
  parameter int DEPTH  = 8192
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              freeze,
  input  logic [ADDR_W-1:0] m0_address,
  input  logic [BE_W-1:0]   m0_byteenable,
  input  logic              m0_read,
  input  logic              m0_write,
  input  logic [DATA_W-1:0] m0_writedata,
  output logic              m0_waitrequest,
  output logic [DATA_W-1:0] m0_readdata,
  output logic              m0_readdatavalid,
  input  logic [ADDR_W-1:0] m1_address,
  input  logic [BE_W-1:0]   m1_byteenable,
  input  logic              m1_read,
  input  logic              m1_write,
  input  logic [DATA_W-1:0] m1_writedata,
  output logic              m1_waitrequest,
  output logic [DATA_W-1:0] m1_readdata,
  output logic              m1_readdatavalid,
  input  logic              clear_start,
  output logic              clear_busy,
  output logic              clear_done,
  output logic [ADDR_W-1:0] mem_address,
  output logic [BE_W-1:0]   mem_byteenable,
  output logic              mem_chipselect,
  output logic              mem_write,
  output logic [DATA_W-1:0] mem_writedata,
  output logic              mem_clken,
  input  logic [DATA_W-1:0] mem_readdata
);
  typedef enum logic [1:0] {IDLE, CLEAR, DONE} state_t;
  state_t            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              rr_q, rr_d;
  logic [1:0]        rv_q, rv_d;
  logic              req0, req1, open, gnt0, gnt1, clr_wr, last;
  assign req0 = m0_read | m0_write;
  assign req1 = m1_read | m1_write;
  // Reset also gates the RAM strobes so an aborted clear leaves untouched words intact.
  assign open   = ~reset & ~freeze & (state_q != CLEAR);
  assign clr_wr = ~reset & ~freeze & (state_q == CLEAR);
  assign gnt0   = open & req0 & (~req1 | ~rr_q);
  assign gnt1   = open & req1 & (~req0 | rr_q);
  assign last   = cnt_q == ADDR_W'(DEPTH - 1);
  assign m0_waitrequest   = req0 & ~gnt0;
  assign m1_waitrequest   = req1 & ~gnt1;
  assign m0_readdata      = mem_readdata;
  assign m1_readdata      = mem_readdata;
  assign m0_readdatavalid = rv_q[0];
  assign m1_readdatavalid = rv_q[1];
  assign clear_busy       = state_q == CLEAR;
  assign clear_done       = state_q == DONE;
  assign mem_clken        = ~freeze;
  assign mem_chipselect   = gnt0 | gnt1 | clr_wr;
  assign mem_write        = clr_wr | (gnt0 & m0_write) | (gnt1 & m1_write);
  assign mem_address      = clr_wr ? cnt_q : gnt1 ? m1_address : m0_address;
  assign mem_writedata    = clr_wr ? '0 : gnt1 ? m1_writedata : m0_writedata;
  assign mem_byteenable   = (gnt1 & m1_write) ? m1_byteenable :
                            (gnt0 & m0_write) ? m0_byteenable : '1;
  always_comb begin
    rr_d    = gnt0 ? 1'b1 : gnt1 ? 1'b0 : rr_q;
    rv_d    = {gnt1 & ~m1_write, gnt0 & ~m0_write};
    cnt_d   = clr_wr ? (last ? '0 : cnt_q + ADDR_W'(1)) : cnt_q;
    state_d = (state_q == IDLE && clear_start) ? CLEAR :
              (clr_wr && last)                 ? DONE  :
              (state_q == DONE)                ? IDLE  : state_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rr_q    <= 1'b0;
      rv_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rr_q    <= rr_d;
      rv_q    <= rv_d;
    end
  end
endmodule

// File: tb/tb_onchip_mem_arbiter.sv
// tb_onchip_mem_arbiter: directed bench with a RAM model and a read-return scoreboard.
module tb_onchip_mem_arbiter;
  logic        clk = 1'b0, reset, freeze, clear_start;
  logic [12:0] m0_address, m1_address, mem_address;
  logic [1:0]  m0_byteenable, m1_byteenable, mem_byteenable;
  logic        m0_read, m0_write, m1_read, m1_write;
  logic [15:0] m0_writedata, m1_writedata, m0_readdata, m1_readdata, mem_writedata, mem_readdata;
  logic        m0_waitrequest, m1_waitrequest, m0_readdatavalid, m1_readdatavalid;
  logic        clear_busy, clear_done, mem_chipselect, mem_write, mem_clken;
  int tests = 0, fails = 0;
  typedef struct { bit own; logic [15:0] d; } exp_t;
  exp_t sb[$];
  logic [15:0] ram [8192];
  logic [15:0] ram_q;

  always #5 clk = ~clk;

  onchip_mem_arbiter dut (
    .clk(clk), .reset(reset), .freeze(freeze),
    .m0_address(m0_address), .m0_byteenable(m0_byteenable), .m0_read(m0_read), .m0_write(m0_write),
    .m0_writedata(m0_writedata), .m0_waitrequest(m0_waitrequest), .m0_readdata(m0_readdata),
    .m0_readdatavalid(m0_readdatavalid),
    .m1_address(m1_address), .m1_byteenable(m1_byteenable), .m1_read(m1_read), .m1_write(m1_write),
    .m1_writedata(m1_writedata), .m1_waitrequest(m1_waitrequest), .m1_readdata(m1_readdata),
    .m1_readdatavalid(m1_readdatavalid),
    .clear_start(clear_start), .clear_busy(clear_busy), .clear_done(clear_done),
    .mem_address(mem_address), .mem_byteenable(mem_byteenable), .mem_chipselect(mem_chipselect),
    .mem_write(mem_write), .mem_writedata(mem_writedata), .mem_clken(mem_clken),
    .mem_readdata(mem_readdata)
  );

  // Single-port RAM with one cycle of read latency and a clock enable.
  always @(posedge clk) begin
    if (mem_clken) begin
      if (mem_chipselect & mem_write) begin
        if (mem_byteenable[0]) ram[mem_address][7:0]  <= mem_writedata[7:0];
        if (mem_byteenable[1]) ram[mem_address][15:8] <= mem_writedata[15:8];
      end
      if (mem_chipselect & ~mem_write) ram_q <= ram[mem_address];
    end
  end
  assign mem_readdata = ram_q;

  initial begin
    #5_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_m(input bit m, input bit r, input bit w, input logic [12:0] a,
                       input logic [1:0] be, input logic [15:0] d);
    if (m) begin
      m1_read = r; m1_write = w; m1_address = a; m1_byteenable = be; m1_writedata = d;
    end else begin
      m0_read = r; m0_write = w; m0_address = a; m0_byteenable = be; m0_writedata = d;
    end
  endtask

  task automatic tick();
    exp_t e;
    @(posedge clk);
    @(negedge clk);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk("rvalid", {30'd0, m1_readdatavalid, m0_readdatavalid}, e.own ? 32'd2 : 32'd1);
      chk("rdata", e.own ? m1_readdata : m0_readdata, e.d);
    end else
      chk("rvalid_idle", {30'd0, m1_readdatavalid, m0_readdatavalid}, 0);
  endtask

  // Check the expected grant for the current inputs, queue any read return, advance one cycle.
  task automatic step(input bit g0, input bit g1, input logic [15:0] d0 = 0, input logic [15:0] d1 = 0);
    #1;
    chk("wait0", m0_waitrequest, (m0_read | m0_write) & ~g0);
    chk("wait1", m1_waitrequest, (m1_read | m1_write) & ~g1);
    chk("cs", mem_chipselect, g0 | g1);
    chk("mwr", mem_write, g0 ? m0_write : g1 ? m1_write : 1'b0);
    if (g0 | g1) begin
      chk("maddr", mem_address, g0 ? m0_address : m1_address);
      chk("mbe", mem_byteenable, (g0 & m0_write) ? m0_byteenable : (g1 & m1_write) ? m1_byteenable : 2'b11);
    end
    if (g0 & m0_read & ~m0_write) sb.push_back('{1'b0, d0});
    if (g1 & m1_read & ~m1_write) sb.push_back('{1'b1, d1});
    tick();
  endtask

  // Runs from the first CLEAR cycle with m0 reading; optional 3-cycle freeze starting at cycle fz.
  task automatic clear_run(input int fz, input int exp_n);
    int n = 0;
    int a = 0;
    while (clear_busy === 1'b1 && n < 9000) begin
      n++;
      freeze = fz > 0 && n >= fz && n < fz + 3;
      #1;
      chk("clr_wait0", m0_waitrequest, 1);
      chk("clr_done_low", clear_done, 0);
      chk("clr_clken", mem_clken, !freeze);
      chk("clr_cs", mem_chipselect, !freeze);
      if (!freeze) begin
        chk("clr_addr", mem_address, a);
        chk("clr_wr", {mem_write, mem_byteenable, mem_writedata}, {13'd0, 1'b1, 2'b11, 16'h0});
        a++;
      end
      tick();
    end
    freeze = 1'b0;
    chk("clr_len", n, exp_n);
    chk("clr_done_pulse", clear_done, 1);
    chk("clr_busy_off", clear_busy, 0);
  endtask

  initial begin
    int k;
    reset = 1'b1; freeze = 1'b0; clear_start = 1'b0;
    set_m(0, 0, 0, 0, 0, 0); set_m(1, 0, 0, 0, 0, 0);
    repeat (2) tick();
    reset = 1'b0;
    #1;
    chk("rst_busy", clear_busy, 0);
    chk("rst_done", clear_done, 0);
    chk("rst_cs", mem_chipselect, 0);
    chk("rst_clken", mem_clken, 1);
    // basic write then read by m0
    set_m(0, 0, 1, 13'h10, 2'b11, 16'hA5A5); step(1, 0);
    set_m(0, 1, 0, 13'h10, 2'b00, 0);        step(1, 0, 16'hA5A5);
    set_m(0, 0, 0, 0, 0, 0);                 step(0, 0);
    // m1 partial-byte write
    set_m(1, 0, 1, 13'd5, 2'b11, 16'hFFFF); step(0, 1);
    set_m(1, 0, 1, 13'd5, 2'b01, 16'h1234); step(0, 1);
    set_m(1, 1, 0, 13'd5, 2'b00, 0);        step(0, 1, 0, 16'hFF34);
    // both requesting: alternate starting with m0
    set_m(0, 1, 0, 13'h10, 0, 0);
    step(1, 0, 16'hA5A5); step(0, 1, 0, 16'hFF34); step(1, 0, 16'hA5A5); step(0, 1, 0, 16'hFF34);
    set_m(1, 0, 0, 0, 0, 0);
    // read+write together is a write
    set_m(0, 1, 1, 13'h20, 2'b11, 16'h0042); step(1, 0);
    set_m(0, 1, 0, 13'h20, 2'b00, 0);        step(1, 0, 16'h0042);
    // freeze in IDLE: pending valid still delivered, no grant, pointer held (m1 favoured)
    set_m(0, 1, 0, 13'h10, 0, 0); step(1, 0, 16'hA5A5);
    set_m(1, 1, 0, 13'd5, 0, 0);
    freeze = 1'b1;
    #1 chk("frz_clken", mem_clken, 0);
    step(0, 0);
    freeze = 1'b0;
    step(0, 1, 0, 16'hFF34);
    set_m(0, 0, 0, 0, 0, 0); set_m(1, 0, 0, 0, 0, 0);
    // clear started together with a read, which still returns
    set_m(0, 1, 0, 13'h10, 0, 0); clear_start = 1'b1;
    step(1, 0, 16'hA5A5);
    clear_start = 1'b0;
    set_m(0, 1, 0, 13'h1FFF, 0, 0);
    clear_run(0, 8192);
    step(1, 0, 16'h0000);
    chk("done_once", clear_done, 0);
    set_m(0, 1, 0, 13'd5, 0, 0);  step(1, 0, 16'h0000);
    set_m(0, 0, 0, 0, 0, 0);
    set_m(1, 1, 0, 13'h10, 0, 0); step(0, 1, 0, 16'h0000);
    set_m(1, 0, 0, 0, 0, 0);
    // clear with a 3-cycle freeze
    clear_start = 1'b1; step(0, 0); clear_start = 1'b0;
    set_m(0, 1, 0, 13'h1FFF, 0, 0);
    clear_run(10, 8195);
    step(1, 0, 16'h0000);
    // reset part-way through a clear
    set_m(0, 0, 1, 13'd50, 2'b11, 16'h1111);  step(1, 0);
    set_m(0, 0, 1, 13'd100, 2'b11, 16'hBEEF); step(1, 0);
    set_m(0, 0, 1, 13'd200, 2'b11, 16'hCAFE); step(1, 0);
    set_m(0, 0, 0, 0, 0, 0);
    clear_start = 1'b1; step(0, 0); clear_start = 1'b0;
    k = 0;
    while (!(clear_busy === 1'b1 && mem_address === 13'd100) && k < 300) begin
      tick();
      k++;
    end
    chk("reach100", k, 100);
    reset = 1'b1;
    #1 chk("rst_gate_cs", mem_chipselect, 0);
    tick();
    reset = 1'b0;
    #1 chk("abort_busy", clear_busy, 0);
    for (int i = 0; i < 4; i++) begin
      chk("abort_no_done", clear_done, 0);
      tick();
    end
    set_m(0, 1, 0, 13'd50, 0, 0);  step(1, 0, 16'h0000);
    set_m(0, 1, 0, 13'd99, 0, 0);  step(1, 0, 16'h0000);
    set_m(0, 1, 0, 13'd100, 0, 0); step(1, 0, 16'hBEEF);
    set_m(0, 1, 0, 13'd200, 0, 0); step(1, 0, 16'hCAFE);
    set_m(0, 0, 0, 0, 0, 0);       step(0, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/onchip_mem_arbiter.md
Name: onchip_mem_arbiter

Overview:
Shares the 16-bit single-port on-chip RAM (8192 words, 13-bit word address, 2 byte lanes) between two Avalon-MM requesters. Uses round-robin arbitration and a one-cycle read pipeline that returns readdatavalid to the correct owner. Includes a hardware clear engine that zero-fills the whole RAM on command. It sits between the Nios-side interconnect and the RAM instance and drives the RAM's address, byteenable, chipselect, write, writedata and clken inputs.

Parameters:
ADDR_W, 13, word-address width
DATA_W, 16, data width
BE_W, 2, byteenable width (DATA_W/8)
DEPTH, 8192, words cleared by the clear engine (at most 2^ADDR_W)

Ports:
clk  in  1  single clock; all logic rising-edge
reset  in  1  synchronous, active-high reset
freeze  in  1  stall everything; RAM clock-enable deasserted
m0_address / m1_address  in  ADDR_W  requester word address
m0_byteenable / m1_byteenable  in  BE_W  write byte lanes
m0_read / m1_read  in  1  read request
m0_write / m1_write  in  1  write request
m0_writedata / m1_writedata  in  DATA_W  write data
m0_waitrequest / m1_waitrequest  out  1  request not accepted this cycle
m0_readdata / m1_readdata  out  DATA_W  equals mem_readdata (pass-through)
m0_readdatavalid / m1_readdatavalid  out  1  readdata valid for this requester
clear_start  in  1  pulse: begin zero-fill
clear_busy  out  1  clear engine active
clear_done  out  1  one-cycle pulse at end of clear
mem_address  out  ADDR_W  to RAM
mem_byteenable  out  BE_W  to RAM
mem_chipselect  out  1  to RAM
mem_write  out  1  to RAM
mem_writedata  out  DATA_W  to RAM
mem_clken  out  1  to RAM clock-enable, equals ~freeze
mem_readdata  in  DATA_W  from RAM; valid one cycle after the read command edge

Behaviour:
- Reset values: state IDLE, rr_ptr=0 (m0 favoured), clear counter 0, clear_busy=0, clear_done=0, both readdatavalid=0.
- Request for requester i: req_i = mi_read | mi_write. If read and write are both high, the access is treated as a write.
- Grant is combinational in the same cycle. Only one requesting: it is granted. Both requesting: rr_ptr wins. After any grant, rr_ptr points at the non-granted requester.
- mi_waitrequest = req_i & ~grant_i. It is 1 for every request during CLEAR or while freeze=1. It is 0 when not requesting.
- Granted access drives mem_* that cycle: mem_chipselect=1 and mem_write=write. mem_byteenable is the requester's byteenable on writes and all-ones on reads. With no grant: mem_chipselect=0 and mem_write=0.
- Read latency is 1: a read granted in cycle N produces mi_readdatavalid=1 in cycle N+1 for the owner only. That valid is a registered flag carrying the owner ID. Back-to-back reads from alternating owners give valid every cycle with correct routing.
- A read granted in the cycle clear_start arrives still returns its readdatavalid.
- freeze=1: no grants, mem_clken=0, clear counter holds, rr_ptr holds. A pending readdatavalid from the previous cycle is still delivered.
- Clear FSM states:
  - IDLE: clear_start → CLEAR next cycle. Arbitration is normal in the start cycle.
  - CLEAR: each non-frozen cycle writes 0 with byteenable all-ones at address=counter, then counter+1. clear_busy=1. The write at DEPTH-1 → DONE.
  - DONE: clear_done=1 for one cycle, clear_busy=0, then → IDLE. Requesters may be granted in the DONE cycle.
- clear_start while in CLEAR or DONE is ignored.
- A full clear takes DEPTH write cycles plus freeze stalls. The counter does not wrap past DEPTH-1.
- Reset mid-clear: immediately IDLE, counter 0, no clear_done, pending readdatavalid dropped.

Test Plan:
- Reset, then m0 writes 0xA5A5 to addr 0x0010, then reads it → m0_waitrequest=0 both cycles; m0_readdatavalid=1 the cycle after the read with readdata 0xA5A5; m1_readdatavalid stays 0.
- m0 and m1 request continuously for 4 cycles → grants m0,m1,m0,m1; loser's waitrequest=1 each cycle; readdatavalid routed to the matching owner one cycle later.
- m1 writes 0x1234 with byteenable 2'b01 over 0xFFFF at addr 5, then reads → 0xFF34.
- clear_start pulse → clear_busy=1 for 8192 cycles; requests held off with waitrequest=1; clear_done pulses once; any address read afterwards → 0x0000.
- freeze=1 for 3 cycles mid-clear → mem_clken=0, counter holds, clear duration extends by 3 cycles; freeze during a request → waitrequest=1.
- reset asserted at clear counter 100 → clear_busy=0 next cycle, no clear_done; addresses ≥100 keep their prior contents.
